piece_drop: RTL
===============

# piece_drop

Active-piece engine for the 8×4 tetris board and the producer end of the board hand-off with the line-clear stage. It loads the locked playfield that the clear stage returns and spawns the selected piece at the top of the board. It then applies left/right moves and gravity ticks with collision checks. When the piece lands, it presents the merged board to the clear stage through a valid/ready handshake.

## Interface
- No parameters; board geometry is fixed at 8 rows × 4 columns.
- Board bit map: cell (row r, col c) = bit 4r+c. Row 0 = bits [3:0] (top, spawn row); row 7 = bits [31:28] (bottom).
- Clock and reset: one clock; reset is synchronous and active-high.
- clka  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- board_in  in  32  locked playfield from the clear stage.
- board_in_valid  in  1  board_in is valid this cycle.
- curr_piece  in  2  piece to spawn; sampled with board_in_valid.
- btn_left  in  1  single-cycle move-left request.
- btn_right  in  1  single-cycle move-right request.
- tick  in  1  single-cycle gravity pulse.
- board_out  out  32  merged board (field | landed piece) for the clear stage.
- board_out_valid  out  1  board_out is valid; held until accepted.
- board_out_ready  in  1  clear stage accepts board_out.
- disp  out  32  live display: field | active piece.
- game_over  out  1  sticky spawn-collision flag.
- pieces_locked  out  8  count of locked pieces; wraps at 255→0.

## Operation
- State: field[31:0], active[31:0] (piece mask), FSM {IDLE, FALL, LOCK, OVER}.
- Spawn masks:
  - 00 = bit 1
  - 01 = bits 1,2
  - 10 = bits 1,2,5,6
  - 11 = bits 1,5,6
- IDLE:
  - On board_in_valid: field ← board_in.
  - If spawn & board_in ≠ 0: go to OVER, set game_over=1, active stays 0.
  - Otherwise: active ← spawn, go to FALL.
- FALL, candidate moves:
  - down = active<<4, legal iff active[31:28]=0 and down&field=0.
  - left = (active>>1), legal iff no active bit in col 0 and left&field=0.
  - right = (active<<1), legal iff no active bit in col 3 and right&field=0.
- FALL, priority per cycle:
  - tick beats any button.
  - btn_left and btn_right together are both ignored.
  - An illegal move leaves active unchanged.
- FALL, tick with down illegal (landing):
  - board_out ← field|active, board_out_valid ← 1, active ← 0.
  - pieces_locked increments; go to LOCK.
- LOCK:
  - board_out and board_out_valid are held stable.
  - On board_out_ready=1: valid drops next cycle, go to IDLE.
  - Buttons and tick are ignored.
- OVER: terminal. All inputs are ignored; exit only via reset.
- board_in_valid outside IDLE is ignored.
- disp = field | active at all times, registered.

## Timing
- All outputs are registered and reflect state after the edge at which inputs were sampled.
- Reset values: state IDLE, field 0, active 0, board_out 0, board_out_valid 0, disp 0, game_over 0, pieces_locked 0.
- Latencies:
  - board_in_valid to disp showing the spawned piece: 1 cycle.
  - Accepted move or tick to disp update: 1 cycle.
  - Landing tick to board_out_valid=1: 1 cycle.
- Handshake: transfer occurs on an edge with board_out_valid=1 and board_out_ready=1. Minimum time from landing tick to next spawn is 3 cycles (LOCK → IDLE → board_in_valid).
- board_out_ready while valid=0 has no effect.
- Reset mid-operation aborts any pending hand-off: valid drops, and no board is delivered.
- Piece reaching row 7 is not a lock by itself; the lock occurs on the next tick.

## Test plan
- Spawn: reset; board_in_valid with board_in=0, curr_piece=00 → next cycle disp=0x0000_0002, FSM in FALL, game_over=0.
- Gravity and lock:
  - 7 ticks → disp=0x2000_0000.
  - 8th tick → board_out=0x2000_0000, board_out_valid=1, pieces_locked=1.
  - Hold board_out_ready=0 for 5 cycles → valid and data stable; ready=1 → valid=0 next cycle.
- Walls: piece 00 spawned; btn_left → disp=0x0000_0001; btn_left again → unchanged; 3× btn_right → 0x0000_0008; btn_right → unchanged.
- Stack collision: board_in=0x2000_0000, curr_piece=00; 6 ticks → disp=0x2200_0000; 7th tick → board_out=0x2200_0000, valid=1.
- Spawn collision: board_in=0x0000_0004, curr_piece=01 → game_over=1, disp=0x0000_0004; subsequent tick/board_in_valid → no change until reset.
- Simultaneous: tick and btn_right in the same cycle with piece 00 at top → disp=0x0000_0020 (gravity only); btn_left+btn_right together → no change.

Source files
------------

// File: rtl/piece_drop_if.sv
// piece_drop_if - board hand-off bundle between the active-piece engine and
// the line-clear stage.
//   board_in        : locked playfield from the clear stage
//   board_in_valid  : board_in (and curr_piece) valid this cycle
//   curr_piece      : piece to spawn, sampled with board_in_valid
//   board_out       : merged board (field | landed piece) to the clear stage
//   board_out_valid : board_out valid, held until accepted
//   board_out_ready : clear stage accepts board_out
// master = piece engine side, slave = clear stage side.
interface piece_drop_if;
   logic [31:0] board_in;
   logic        board_in_valid;
   logic [1:0]  curr_piece;
   logic [31:0] board_out;
   logic        board_out_valid;
   logic        board_out_ready;

   modport master (
      input  board_in,
      input  board_in_valid,
      input  curr_piece,
      input  board_out_ready,
      output board_out,
      output board_out_valid
   );

   modport slave (
      output board_in,
      output board_in_valid,
      output curr_piece,
      output board_out_ready,
      input  board_out,
      input  board_out_valid
   );
endinterface

// File: rtl/piece_drop.sv
// piece_drop - active-piece engine for an 8x4 tetris board.
// Loads the locked field from the clear stage, spawns the selected piece in
// the top rows, applies left/right moves and gravity ticks with collision
// checks, and hands the merged board back once the piece lands.
// Board bit map: cell (row r, col c) = bit 4r+c, row 0 on top.
//   clka          : clock, rising edge
//   reset         : synchronous, active-high
//   bus           : board hand-off interface (master side)
//   btn_left      : single-cycle move-left request
//   btn_right     : single-cycle move-right request
//   tick          : single-cycle gravity pulse
//   disp          : registered field | active piece
//   game_over     : sticky spawn-collision flag
//   pieces_locked : count of locked pieces, wraps at 255
//
// state  | meaning
// IDLE   | waiting for a field + piece from the clear stage
// FALL   | piece active, accepting moves and gravity
// LOCK   | landed board presented, waiting for board_out_ready
// OVER   | spawn collided; frozen until reset
module piece_drop (
   input  logic                clka,
   input  logic                reset,
   piece_drop_if.master        bus,
   input  logic                btn_left,
   input  logic                btn_right,
   input  logic                tick,
   output logic [31:0]         disp,
   output logic                game_over,
   output logic [7:0]          pieces_locked
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FALL = 2'd1,
      S_LOCK = 2'd2,
      S_OVER = 2'd3
   } state_t;

   localparam logic [31:0] COL0_MASK = 32'h1111_1111;
   localparam logic [31:0] COL3_MASK = 32'h8888_8888;

   state_t      state_q, state_d;
   logic [31:0] field_q, field_d;
   logic [31:0] active_q, active_d;
   logic [31:0] board_out_q, board_out_d;
   logic        board_out_valid_q, board_out_valid_d;
   logic [31:0] disp_q, disp_d;
   logic        game_over_q, game_over_d;
   logic [7:0]  pieces_locked_q, pieces_locked_d;

   logic [31:0] spawn_mask;
   logic        spawn_hit;
   logic [31:0] down_mv, left_mv, right_mv;
   logic        down_ok, left_ok, right_ok;
   logic        one_btn;

   always_comb begin
      spawn_mask = 32'h0000_0000;
      case (bus.curr_piece)
         2'b00:   spawn_mask = 32'h0000_0002;
         2'b01:   spawn_mask = 32'h0000_0006;
         2'b10:   spawn_mask = 32'h0000_0066;
         default: spawn_mask = 32'h0000_0062;
      endcase
   end

   assign spawn_hit = (spawn_mask & bus.board_in) != 32'h0;

   // Shifting right by one column moves a piece left; the column masks stop
   // a piece wrapping onto the neighbouring row.
   assign down_mv  = active_q << 4;
   assign left_mv  = active_q >> 1;
   assign right_mv = active_q << 1;
   assign down_ok  = (active_q[31:28] == 4'h0) && ((down_mv & field_q) == 32'h0);
   assign left_ok  = ((active_q & COL0_MASK) == 32'h0) && ((left_mv & field_q) == 32'h0);
   assign right_ok = ((active_q & COL3_MASK) == 32'h0) && ((right_mv & field_q) == 32'h0);
   assign one_btn  = btn_left ^ btn_right;

   always_ff @(posedge clka) begin
      if (reset) begin
         state_q           <= S_IDLE;
         field_q           <= 32'h0;
         active_q          <= 32'h0;
         board_out_q       <= 32'h0;
         board_out_valid_q <= 1'b0;
         disp_q            <= 32'h0;
         game_over_q       <= 1'b0;
         pieces_locked_q   <= 8'h0;
      end else begin
         state_q           <= state_d;
         field_q           <= field_d;
         active_q          <= active_d;
         board_out_q       <= board_out_d;
         board_out_valid_q <= board_out_valid_d;
         disp_q            <= disp_d;
         game_over_q       <= game_over_d;
         pieces_locked_q   <= pieces_locked_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.board_in_valid) begin
               state_d = spawn_hit ? S_OVER : S_FALL;
            end
         end
         S_FALL: begin
            if (tick && !down_ok) begin
               state_d = S_LOCK;
            end
         end
         S_LOCK: begin
            if (bus.board_out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_OVER;
      endcase
   end

   always_comb begin
      field_d           = field_q;
      active_d          = active_q;
      board_out_d       = board_out_q;
      board_out_valid_d = board_out_valid_q;
      game_over_d       = game_over_q;
      pieces_locked_d   = pieces_locked_q;
      case (state_q)
         S_IDLE: begin
            if (bus.board_in_valid) begin
               field_d = bus.board_in;
               if (spawn_hit) begin
                  game_over_d = 1'b1;
               end else begin
                  active_d = spawn_mask;
               end
            end
         end
         S_FALL: begin
            if (tick) begin
               if (down_ok) begin
                  active_d = down_mv;
               end else begin
                  board_out_d       = field_q | active_q;
                  board_out_valid_d = 1'b1;
                  active_d          = 32'h0;
                  pieces_locked_d   = pieces_locked_q + 8'd1;
               end
            end else if (one_btn) begin
               if (btn_left && left_ok) begin
                  active_d = left_mv;
               end else if (btn_right && right_ok) begin
                  active_d = right_mv;
               end
            end
         end
         S_LOCK: begin
            if (bus.board_out_ready) begin
               board_out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
      // Display is registered from the next-state values so it lines up
      // with the field/active update on the same edge.
      disp_d = field_d | active_d;
   end

   assign bus.board_out       = board_out_q;
   assign bus.board_out_valid = board_out_valid_q;
   assign disp                = disp_q;
   assign game_over           = game_over_q;
   assign pieces_locked       = pieces_locked_q;

endmodule
